regfile_port_ctrl: RTL
======================

Name: regfile_port_ctrl

Overview:
Sits between the pipeline and regfile and owns the regfile write port and read port 2.
- After reset, sweeps r1..r31 to zero through the write port while stalling the pipeline.
- Then gives pipeline writeback absolute priority on the write port and pipeline decode priority on read port 2.
- Serves a debug/loader requester on idle cycles through a req/ack handshake, with a starvation-triggered stall.

Parameters:
DATA_W, 32, register width (matches `RegBus)
ADDR_W, 5, register address width (matches `RegAddrBus)
STARVE_LIM, 8, cycles a pending debug request may wait before stall_req is raised

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
wb_we / wb_waddr / wb_wdata  in  1/ADDR_W/DATA_W  pipeline writeback request
id_re2 / id_raddr2  in  1/ADDR_W  pipeline read-port-2 request
dbg_req / dbg_wr  in  1/1  debug request (held until ack); 1=write, 0=read
dbg_addr / dbg_wdata  in  ADDR_W/DATA_W  debug address, write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  registered read result, valid with dbg_ack, held afterwards
rf_we / rf_waddr / rf_wdata  out  1/ADDR_W/DATA_W  to regfile write port
rf_re2 / rf_raddr2  out  1/ADDR_W  to regfile read port 2
rf_rdata2  in  DATA_W  regfile read port 2 data (combinational)
stall_req  out  1  pipeline stall request
init_done  out  1  high once sweep complete

Behaviour:
Reset:
- rst high forces, asynchronously: state=INIT, sweep_addr=1, starve_cnt=0, dbg_ack=0, dbg_rdata=0, init_done=0, stall_req=1.
- Any in-flight debug request is abandoned; the requester re-issues it.

State INIT:
- Each cycle drives rf_we=1, rf_waddr=sweep_addr, rf_wdata=0, then increments sweep_addr.
- Leaves INIT after the write to address 31, i.e. 31 cycles after reset release.
- stall_req=1 and init_done=0 throughout. wb_we and dbg_req are ignored (wb_we high in INIT is a protocol error; bench asserts it never occurs).
- rf_re2 passes id_re2/id_raddr2 through.

Next state RUN:
- init_done=1 until the next reset.
- Write port: if wb_we, pass the wb_* signals through (same cycle, combinational). Otherwise, if dbg_req&dbg_wr, drive dbg_addr/dbg_wdata with rf_we=1 (grant). Otherwise rf_we=0.
- Read port 2: if id_re2, pass id_* through. Otherwise, if dbg_req&!dbg_wr, drive rf_re2=1, rf_raddr2=dbg_addr (grant) and capture rf_rdata2 into dbg_rdata at the clock edge. Otherwise rf_re2=0, rf_raddr2=id_raddr2.
- On a grant, move to ACK. A write and a read grant cannot coincide: there is one request.
- The regfile forwards same-cycle writeback data on an address match, so a debug read of a register being written returns the new value. A debug read of r0 returns 0. A debug write to r0 is acked with no effect.

State ACK:
- dbg_ack=1 for exactly one cycle; no debug grant this cycle, because dbg_req is still high.
- Pipeline passthrough is unchanged. Return to RUN.
- A requester may raise a new dbg_req the cycle after ack; earliest regrant is that cycle, giving a 2-cycle minimum per transaction.

Starvation:
- In RUN, starve_cnt increments each cycle dbg_req is high and not granted. It is cleared on grant or when dbg_req is low.
- It saturates at STARVE_LIM. While starve_cnt==STARVE_LIM, stall_req=1.
- The pipeline drains writeback and drops id_re2, so a grant follows and stall_req drops the cycle after grant.

Outputs:
- dbg_ack, dbg_rdata, init_done, state and counters are registered.
- rf_* and stall_req are combinational from state and inputs (stall_req decodes from registered state only, so no combinational loop to the pipeline).

Decomposition:
- Use the shared defines header: `RegBus, `RegAddrBus, `WriteEnable, `ReadEnable, `ZeroWord, `RstEnable.
- Add state encodings RPC_INIT/RPC_RUN/RPC_ACK and STARVE_LIM default there.
- No sub-module needed. The starvation counter may be a small saturating-counter instance, sat_counter, if one already exists; otherwise inline it.

Test Plan:
- Reset then release → rf_we=1 for 31 cycles, addresses 1..31, data 0; init_done rises on cycle 32; stall_req high through cycle 31. Regfile readback of every register = 0.
- RUN, wb_we=0, debug write r5=0xDEADBEEF → rf_we same cycle with addr 5; dbg_ack pulses the next cycle; later debug read r5 returns 0xDEADBEEF in dbg_rdata with ack.
- Debug read r7 while wb_we=1 writes r7=0x12345678 and id_re2=0 → dbg_rdata=0x12345678 (forwarding). Debug read r0 → 0.
- wb_we held high 20 cycles with debug write pending → no grant; stall_req rises after 8 waiting cycles; wb_we drops → grant that cycle, ack next cycle, stall_req low after grant.
- Back-to-back debug reads with req re-raised immediately after ack → grants every 2 cycles, no double ack per request.
- Assert rst mid-transaction, the cycle of grant → dbg_ack=0 immediately; sweep restarts at r1; pending request not acked.

Source files
------------

// File: rtl/regfile_port_ctrl_pkg.sv
// rtl/regfile_port_ctrl_pkg.sv - shared widths, enables and state encoding
// Purpose: constants and the controller state type, imported by the
//          interface and the top.
// Ports:   none (package).
package regfile_port_ctrl_pkg;

  localparam int REG_BUS_W      = 32;  // register width
  localparam int REG_ADDR_BUS_W = 5;   // register address width
  localparam int STARVE_LIM_DEF = 8;   // debug wait cycles before stall

  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

  typedef enum logic [1:0] {
    RPC_INIT = 2'd0,  // zero-sweep of r1..r31
    RPC_RUN  = 2'd1,  // normal arbitration
    RPC_ACK  = 2'd2   // one-cycle debug acknowledge
  } rpc_state_t;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// rtl/regfile_port_ctrl_if.sv - pipeline/debug/regfile bundle
// Purpose: groups every non-clock signal of regfile_port_ctrl.
// Ports (signals):
//   wb_we/wb_waddr/wb_wdata      pipeline writeback request
//   id_re2/id_raddr2             pipeline read-port-2 request
//   dbg_req/dbg_wr/dbg_addr/dbg_wdata, dbg_ack/dbg_rdata  debug handshake
//   rf_we/rf_waddr/rf_wdata, rf_re2/rf_raddr2, rf_rdata2   regfile ports
//   stall_req, init_done         status to the pipeline
// Modports: slave = the controller, master = its environment.
interface regfile_port_ctrl_if
  import regfile_port_ctrl_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_BUS_W
);

  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              id_re2;
  logic [ADDR_W-1:0] id_raddr2;
  logic              dbg_req;
  logic              dbg_wr;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_re2;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata2;
  logic              stall_req;
  logic              init_done;

  modport slave (
    input  wb_we, wb_waddr, wb_wdata, id_re2, id_raddr2,
    input  dbg_req, dbg_wr, dbg_addr, dbg_wdata, rf_rdata2,
    output dbg_ack, dbg_rdata, rf_we, rf_waddr, rf_wdata,
    output rf_re2, rf_raddr2, stall_req, init_done
  );

  modport master (
    output wb_we, wb_waddr, wb_wdata, id_re2, id_raddr2,
    output dbg_req, dbg_wr, dbg_addr, dbg_wdata, rf_rdata2,
    input  dbg_ack, dbg_rdata, rf_we, rf_waddr, rf_wdata,
    input  rf_re2, rf_raddr2, stall_req, init_done
  );

endinterface

// File: rtl/regfile_port_ctrl.sv
// rtl/regfile_port_ctrl.sv - regfile write port / read port 2 owner
// Purpose: zero-sweeps r1..r31 after reset, then arbitrates the write port
//          (writeback first) and read port 2 (decode first) against a
//          debug/loader requester, stalling the pipeline if it starves.
// Ports:
//   clk  single clock
//   rst  asynchronous, active-high reset
//   bus  regfile_port_ctrl_if.slave (pipeline, debug and regfile signals)
module regfile_port_ctrl
  import regfile_port_ctrl_pkg::*;
#(
  parameter int DATA_W     = REG_BUS_W,
  parameter int ADDR_W     = REG_ADDR_BUS_W,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_port_ctrl_if.slave    bus
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  rpc_state_t        state, state_next;
  logic [ADDR_W-1:0] sweep_addr;
  logic [CNT_W-1:0]  starve_cnt, starve_next;
  logic              wr_grant, rd_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RPC_INIT;
      sweep_addr    <= ADDR_W'(1);
      starve_cnt    <= '0;
      bus.dbg_ack   <= 1'b0;
      bus.dbg_rdata <= '0;
      bus.init_done <= 1'b0;
    end else begin
      state       <= state_next;
      starve_cnt  <= starve_next;
      bus.dbg_ack <= wr_grant | rd_grant;
      if (state == RPC_INIT)
        sweep_addr <= sweep_addr + ADDR_W'(1);
      // rf_rdata2 already carries same-cycle writeback forwarding.
      if (rd_grant)
        bus.dbg_rdata <= bus.rf_rdata2;
      if (state == RPC_INIT && state_next == RPC_RUN)
        bus.init_done <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    wr_grant      = 1'b0;
    rd_grant      = 1'b0;
    bus.rf_we     = 1'b0;
    bus.rf_waddr  = bus.wb_waddr;
    bus.rf_wdata  = bus.wb_wdata;
    bus.rf_re2    = bus.id_re2;
    bus.rf_raddr2 = bus.id_raddr2;

    case (state)
      RPC_INIT: begin
        bus.rf_we    = WRITE_ENABLE;
        bus.rf_waddr = sweep_addr;
        bus.rf_wdata = {DATA_W{1'b0}};
        if (sweep_addr == {ADDR_W{1'b1}})
          state_next = RPC_RUN;
      end
      RPC_RUN: begin
        bus.rf_we = bus.wb_we;
        if (!bus.wb_we && bus.dbg_req && bus.dbg_wr) begin
          wr_grant     = 1'b1;
          bus.rf_we    = WRITE_ENABLE;
          bus.rf_waddr = bus.dbg_addr;
          bus.rf_wdata = bus.dbg_wdata;
        end
        if (!bus.id_re2 && bus.dbg_req && !bus.dbg_wr) begin
          rd_grant      = 1'b1;
          bus.rf_re2    = READ_ENABLE;
          bus.rf_raddr2 = bus.dbg_addr;
        end
        if (wr_grant || rd_grant)
          state_next = RPC_ACK;
      end
      RPC_ACK: begin
        // dbg_req is still high here; granting it again would double-ack.
        bus.rf_we  = bus.wb_we;
        state_next = RPC_RUN;
      end
      default: state_next = RPC_INIT;
    endcase
  end

  // Starvation counter: counts blocked RUN cycles, saturating at the limit.
  always_comb begin
    starve_next = starve_cnt;
    if (state == RPC_RUN) begin
      if (!bus.dbg_req || wr_grant || rd_grant)
        starve_next = '0;
      else if (starve_cnt != CNT_W'(STARVE_LIM))
        starve_next = starve_cnt + CNT_W'(1);
    end
  end

  // Decoded from registered state only, so no loop back into the pipeline.
  assign bus.stall_req = (state == RPC_INIT) ||
                         (starve_cnt == CNT_W'(STARVE_LIM));

endmodule
